// File: rtl/mips_store_monitor_pkg.sv
// Shared types for the MIPS store monitor: FSM states, failure codes, table entry.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package mips_mon_pkg;

    // Widest store port the expected-table entry can hold. Narrower ports zero-extend.
    localparam int MON_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISMATCH = 2'd1,
        TIMEOUT  = 2'd2
    } fail_code_t;

    typedef struct packed {
        logic [MON_WIDTH-1:0] addr;
        logic [MON_WIDTH-1:0] data;
    } store_entry_t;

    // Saturating increment for the 8-bit ignore counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mips_store_monitor_if.sv
// Core data-memory write port as seen by the store monitor.
// Latency: n/a (wires only).
// Backpressure: none; the monitor only observes, the core never stalls.
interface mips_store_monitor_if #(
    parameter int WIDTH = 32
) ();
    logic             memwrite;
    logic [WIDTH-1:0] dataaddr;
    logic [WIDTH-1:0] writedata;

    modport master (output memwrite, output dataaddr, output writedata);
    modport slave  (input  memwrite, input  dataaddr, input  writedata);
endinterface

// File: rtl/mips_store_table.sv
// Expected-store register file: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; writes always commit when we is high.
module mips_store_table
    import mips_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  store_entry_t             wentry,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output store_entry_t             rentry
);

    store_entry_t mem_q [DEPTH];
    store_entry_t mem_d [DEPTH];

    // Next table contents: copy, then overlay the single write.
    always_comb begin
        mem_d = mem_q;
        if (we && (int'(widx) < DEPTH)) begin
            mem_d[widx] = wentry;
        end
    end

    // Table register; reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read of the entry currently being waited for.
    always_comb begin
        rentry = '0;
        if (int'(ridx) < DEPTH) begin
            rentry = mem_q[ridx];
        end
    end

endmodule

// File: rtl/mips_store_monitor.sv
// Checks core stores against an ordered expected table, with scratch-address skip and timeout.
// Latency: pass/fail/status register one cycle after the deciding store or timeout cycle.
// Backpressure: none; the store port is observed only and never stalled.
module mips_store_monitor
    import mips_mon_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 1000,
    parameter int IGNORE_EN   = 1,
    parameter int IGNORE_ADDR = 80
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic [$clog2(DEPTH)-1:0]     cfg_idx,
    input  logic [WIDTH-1:0]             cfg_addr,
    input  logic [WIDTH-1:0]             cfg_data,
    input  logic [$clog2(DEPTH+1)-1:0]   cfg_count,
    input  logic                         start,
    input  logic                         clear,
    mips_store_monitor_if.slave          st,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   fail_code,
    output logic [$clog2(DEPTH)-1:0]     fail_idx,
    output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
    output logic [7:0]                   ignore_cnt,
    output logic [$clog2(TIMEOUT+1)-1:0] cycle_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);

    mon_state_t    state_q,      state_d;
    logic [CW-1:0] count_q,      count_d;
    logic [CW-1:0] match_cnt_q,  match_cnt_d;
    logic [7:0]    ignore_cnt_q, ignore_cnt_d;
    logic [TW-1:0] cycle_cnt_q,  cycle_cnt_d;
    fail_code_t    fail_code_q,  fail_code_d;
    logic [IW-1:0] fail_idx_q,   fail_idx_d;

    logic          table_we;
    store_entry_t  wr_entry;
    store_entry_t  rd_entry;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cfg_count_sat;
    logic          store_hit;
    logic          store_ign;
    logic          last_entry;
    logic          timeout_hit;
    logic          run_exit;

    // The table pointer is the match count: entries are consumed strictly in order.
    assign ptr = match_cnt_q[IW-1:0];

    assign wr_entry = '{addr: MON_WIDTH'(cfg_addr), data: MON_WIDTH'(cfg_data)};

    mips_store_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (table_we),
        .widx   (cfg_idx),
        .wentry (wr_entry),
        .ridx   (ptr),
        .rentry (rd_entry)
    );

    // Store classification. Address/data are matched before the scratch rule so an
    // expected entry at the scratch address can still be checked.
    always_comb begin
        cfg_count_sat = (cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_count;
        store_hit     = st.memwrite
                        && (st.dataaddr  == rd_entry.addr[WIDTH-1:0])
                        && (st.writedata == rd_entry.data[WIDTH-1:0]);
        store_ign     = st.memwrite && (IGNORE_EN != 0)
                        && (st.dataaddr == WIDTH'(IGNORE_ADDR));
        last_entry    = ((match_cnt_q + CW'(1)) == count_q);
        timeout_hit   = (cycle_cnt_q == TW'(TIMEOUT - 1));
    end

    // Next-state and counter logic; clear overrides everything else.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        match_cnt_d  = match_cnt_q;
        ignore_cnt_d = ignore_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        fail_code_d  = fail_code_q;
        fail_idx_d   = fail_idx_q;
        table_we     = 1'b0;
        run_exit     = 1'b0;

        unique case (state_q)
            IDLE: begin
                table_we = cfg_we;
                if (start) begin
                    count_d      = cfg_count_sat;
                    match_cnt_d  = '0;
                    ignore_cnt_d = '0;
                    cycle_cnt_d  = '0;
                    fail_code_d  = NONE;
                    fail_idx_d   = '0;
                    state_d      = (cfg_count_sat == '0) ? PASS : RUN;
                end
            end
            RUN: begin
                if (store_hit) begin
                    match_cnt_d = match_cnt_q + CW'(1);
                    if (last_entry) begin
                        state_d  = PASS;
                        run_exit = 1'b1;
                    end
                end else if (store_ign) begin
                    ignore_cnt_d = sat_inc8(ignore_cnt_q);
                end else if (st.memwrite) begin
                    state_d     = FAIL;
                    fail_code_d = MISMATCH;
                    fail_idx_d  = ptr;
                    run_exit    = 1'b1;
                end
                // Final match beats the timeout because run_exit is already set.
                if (!run_exit && timeout_hit) begin
                    state_d     = FAIL;
                    fail_code_d = mips_mon_pkg::TIMEOUT;
                    run_exit    = 1'b1;
                end
                // The deciding cycle is not counted, so a timeout leaves TIMEOUT-1.
                if (!run_exit) begin
                    cycle_cnt_d = cycle_cnt_q + TW'(1);
                end
            end
            PASS, FAIL: begin
                // Sticky: everything frozen until clear or reset.
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d      = IDLE;
            match_cnt_d  = '0;
            ignore_cnt_d = '0;
            cycle_cnt_d  = '0;
            fail_code_d  = NONE;
            fail_idx_d   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            match_cnt_q  <= '0;
            ignore_cnt_q <= '0;
            cycle_cnt_q  <= '0;
            fail_code_q  <= NONE;
            fail_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            match_cnt_q  <= match_cnt_d;
            ignore_cnt_q <= ignore_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            fail_code_q  <= fail_code_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    // Status is a pure decode of registered state, so it never glitches on store inputs.
    assign busy       = (state_q == RUN);
    assign pass       = (state_q == PASS);
    assign fail       = (state_q == FAIL);
    assign done       = pass | fail;
    assign fail_code  = fail_code_q;
    assign fail_idx   = fail_idx_q;
    assign match_cnt  = match_cnt_q;
    assign ignore_cnt = ignore_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_mips_store_monitor.sv
module tb_mips_store_monitor;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int TO = 20;

    typedef struct {
        bit     pass;
        int     code;
        int     idx;
        int     mcnt;
        int     icnt;
        int     ccnt;
        longint dcyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic cfg_we, start, clear;
    logic [2:0]  cfg_idx;
    logic [W-1:0] cfg_addr, cfg_data;
    logic [3:0]  cfg_count;

    logic busy_a, done_a, pass_a, fail_a, busy_b, done_b, pass_b, fail_b;
    logic [1:0] fc_a, fc_b;
    logic [2:0] fi_a, fi_b;
    logic [3:0] mc_a, mc_b;
    logic [7:0] ic_a, ic_b;
    logic [4:0] cc_a, cc_b;

    mips_store_monitor_if #(.WIDTH(W)) st_if ();

    always #5 clk = ~clk;

    // dut_a ignores the scratch address, dut_b checks every store.
    mips_store_monitor #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .IGNORE_EN(1), .IGNORE_ADDR(80)) dut_a (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .clear(clear), .st(st_if),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a), .fail_code(fc_a),
        .fail_idx(fi_a), .match_cnt(mc_a), .ignore_cnt(ic_a), .cycle_cnt(cc_a));

    mips_store_monitor #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .IGNORE_EN(0), .IGNORE_ADDR(80)) dut_b (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .clear(clear), .st(st_if),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b), .fail_code(fc_b),
        .fail_idx(fi_b), .match_cnt(mc_b), .ignore_cnt(ic_b), .cycle_cnt(cc_b));

    int     vectors = 0;
    int     errors  = 0;
    longint cyc     = 0;
    exp_t   qa[$];
    exp_t   qb[$];

    int tbl_addr [D];
    int tbl_data [D];
    bit s_mw [64];
    int s_a  [64];
    int s_d  [64];
    int slen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk the store list in RUN-cycle order applying the checking rules.
    task automatic model(input bit ign, input int cnt, input longint c0, output exp_t e);
        int n, p, ig, a, d;
        bit mw;
        e  = '{default: 0};
        n  = (cnt > D) ? D : cnt;
        p  = 0;
        ig = 0;
        if (n == 0) begin
            e.pass = 1;
            e.dcyc = c0 + 1;
            return;
        end
        for (int k = 0; k < TO; k++) begin
            mw = (k < slen) ? s_mw[k] : 1'b0;
            a  = s_a[k];
            d  = s_d[k];
            if (mw) begin
                if (a == tbl_addr[p] && d == tbl_data[p]) begin
                    p++;
                    if (p == n) begin
                        e.pass = 1; e.mcnt = p; e.icnt = ig; e.ccnt = k; e.dcyc = c0 + k + 2;
                        return;
                    end
                end else if (ign && a == 80) begin
                    if (ig < 255) ig++;
                end else begin
                    e.code = 1; e.idx = p; e.mcnt = p; e.icnt = ig; e.ccnt = k; e.dcyc = c0 + k + 2;
                    return;
                end
            end
            if (k == TO - 1) begin
                e.code = 2; e.mcnt = p; e.icnt = ig; e.ccnt = k; e.dcyc = c0 + k + 2;
                return;
            end
        end
    endtask

    task automatic cmp_done(input string t, input exp_t e, input logic p, input logic f,
                            input logic [1:0] fc, input logic [2:0] fi, input logic [3:0] mc,
                            input logic [7:0] ic, input logic [4:0] cc, input bit first);
        chk({t, "_pass"}, p, e.pass);
        chk({t, "_fail"}, f, !e.pass);
        chk({t, "_fail_code"}, fc, e.code);
        chk({t, "_fail_idx"}, fi, e.idx);
        chk({t, "_match_cnt"}, mc, e.mcnt);
        chk({t, "_ignore_cnt"}, ic, e.icnt);
        chk({t, "_cycle_cnt"}, cc, e.ccnt);
        if (first) chk({t, "_done_cycle"}, cyc, e.dcyc);
    endtask

    // Monitors: pop on the rising edge of done, then keep checking the frozen status.
    initial begin : mon_a
        exp_t cur;
        bit have = 0;
        bit prev = 0;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
                else begin
                    cur  = qa.pop_front();
                    have = 1;
                    cmp_done("a", cur, pass_a, fail_a, fc_a, fi_a, mc_a, ic_a, cc_a, 1);
                end
            end else if (done_a && have) begin
                cmp_done("a_sticky", cur, pass_a, fail_a, fc_a, fi_a, mc_a, ic_a, cc_a, 0);
            end
            if (!done_a) have = 0;
            prev = done_a;
        end
    end

    initial begin : mon_b
        exp_t cur;
        bit have = 0;
        bit prev = 0;
        forever begin
            @(negedge clk);
            if (done_b && !prev) begin
                if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
                else begin
                    cur  = qb.pop_front();
                    have = 1;
                    cmp_done("b", cur, pass_b, fail_b, fc_b, fi_b, mc_b, ic_b, cc_b, 1);
                end
            end else if (done_b && have) begin
                cmp_done("b_sticky", cur, pass_b, fail_b, fc_b, fi_b, mc_b, ic_b, cc_b, 0);
            end
            if (!done_b) have = 0;
            prev = done_b;
        end
    end

    task automatic idle();
        cfg_we = 0; start = 0; clear = 0; st_if.memwrite = 0;
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_busy"}, {busy_a, busy_b}, 0);
        chk({t, "_done"}, {done_a, pass_a, fail_a, done_b, pass_b, fail_b}, 0);
        chk({t, "_codes"}, {fc_a, fi_a, fc_b, fi_b}, 0);
        chk({t, "_counts"}, {mc_a, ic_a, cc_a, mc_b, ic_b, cc_b}, 0);
    endtask

    task automatic set_sched(input int i, input bit mw, input int a, input int d);
        s_mw[i] = mw; s_a[i] = a; s_d[i] = d;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < D; i++) begin tbl_addr[i] = 0; tbl_data[i] = 0; end
    endtask

    task automatic program_table(input int cnt, input bit overlap, output longint c0);
        for (int i = 0; i < D; i++) begin
            @(negedge clk); idle();
            cfg_we = 1; cfg_idx = 3'(i); cfg_addr = W'(tbl_addr[i]); cfg_data = W'(tbl_data[i]);
            if (i == D - 1 && overlap) begin start = 1; cfg_count = 4'(cnt); c0 = cyc; end
        end
        if (!overlap) begin
            @(negedge clk); idle();
            start = 1; cfg_count = 4'(cnt); c0 = cyc;
        end
    endtask

    task automatic start_only(input int cnt, output longint c0);
        @(negedge clk); idle();
        start = 1; cfg_count = 4'(cnt); c0 = cyc;
    endtask

    task automatic push_exp(input int cnt, input longint c0);
        exp_t e;
        model(1, cnt, c0, e); qa.push_back(e);
        model(0, cnt, c0, e); qb.push_back(e);
    endtask

    // Drive the store list; sprinkle table writes that must be ignored outside IDLE.
    task automatic run_sched();
        for (int k = 0; k < slen; k++) begin
            @(negedge clk); idle();
            st_if.memwrite = s_mw[k]; st_if.dataaddr = W'(s_a[k]); st_if.writedata = W'(s_d[k]);
            if ($urandom_range(0, 3) == 0) begin
                cfg_we = 1; cfg_idx = 3'($urandom_range(0, 7)); cfg_addr = $urandom; cfg_data = $urandom;
            end
        end
    endtask

    task automatic finish_test();
        @(negedge clk); idle();
        for (int i = 0; i < TO + 10; i++) begin
            if (done_a && done_b) break;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            st_if.memwrite = 1; st_if.dataaddr = W'(4 * $urandom_range(0, 24)); st_if.writedata = W'($urandom_range(0, 15));
            start = 1; cfg_count = 4'($urandom_range(0, 8));
            cfg_we = 1; cfg_idx = 3'($urandom_range(0, 7)); cfg_addr = $urandom; cfg_data = $urandom;
        end
        @(negedge clk); idle(); clear = 1;
        @(negedge clk); idle();
        chk_zero("after_clear");
    endtask

    task automatic run_test(input int cnt, input bit overlap);
        longint c0;
        program_table(cnt, overlap, c0);
        push_exp(cnt, c0);
        run_sched();
        finish_test();
    endtask

    task automatic build_random(input int cnt);
        int n;
        n    = (cnt > D) ? D : cnt;
        slen = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin set_sched(slen, 0, 0, 0); slen++; end
            if ($urandom_range(0, 3) == 0) begin set_sched(slen, 1, 80, $urandom_range(0, 15)); slen++; end
            if ($urandom_range(0, 9) == 0) set_sched(slen, 1, tbl_addr[i] + 4, tbl_data[i]);
            else set_sched(slen, 1, tbl_addr[i], tbl_data[i]);
            slen++;
        end
    endtask

    initial begin : stim
        longint c0;
        idle();
        reset = 1; cfg_idx = 0; cfg_addr = 0; cfg_data = 0; cfg_count = 0;
        st_if.dataaddr = 0; st_if.writedata = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 0;

        // Scratch store then the expected store.
        clear_tbl(); tbl_addr[0] = 84; tbl_data[0] = 7;
        set_sched(0, 1, 80, 3); set_sched(1, 1, 84, 7); slen = 2;
        run_test(1, 0);

        // Wrong address.
        set_sched(0, 1, 88, 7); slen = 1;
        run_test(1, 0);

        // No stores: timeout.
        slen = 0;
        run_test(1, 1);

        // Three entries in order with gaps, then out of order.
        clear_tbl();
        tbl_addr[0] = 0; tbl_data[0] = 5; tbl_addr[1] = 4; tbl_data[1] = 10; tbl_addr[2] = 84; tbl_data[2] = 7;
        set_sched(0, 1, 0, 5); set_sched(1, 0, 0, 0); set_sched(2, 1, 4, 10);
        set_sched(3, 0, 0, 0); set_sched(4, 0, 0, 0); set_sched(5, 1, 84, 7); slen = 6;
        run_test(3, 0);
        set_sched(0, 1, 4, 10); slen = 1;
        run_test(3, 0);

        // Reset in the middle of a run after one match.
        program_table(3, 0, c0);
        @(negedge clk); idle(); st_if.memwrite = 1; st_if.dataaddr = 0; st_if.writedata = 5;
        @(negedge clk); idle();
        chk("midrun_match_cnt", {mc_a, mc_b}, {4'd1, 4'd1});
        chk("midrun_busy", {busy_a, busy_b}, 2'b11);
        reset = 1;
        @(negedge clk); reset = 0;
        chk_zero("midrun_reset");
        // Table was zeroed: entry 0 is now (0,0).
        clear_tbl();
        set_sched(0, 1, 0, 0); slen = 1;
        c0 = 0; start_only(1, c0); push_exp(1, c0); run_sched(); finish_test();
        tbl_addr[0] = 0; tbl_data[0] = 5; tbl_addr[1] = 4; tbl_data[1] = 10; tbl_addr[2] = 84; tbl_data[2] = 7;
        set_sched(0, 1, 0, 5); set_sched(1, 1, 4, 10); set_sched(2, 1, 84, 7); slen = 3;
        run_test(3, 1);

        // Empty run passes at once; table survives clear; clear beats start.
        clear_tbl(); tbl_addr[0] = 84; tbl_data[0] = 7;
        slen = 0;
        run_test(0, 0);
        set_sched(0, 1, 84, 7); slen = 1;
        start_only(1, c0); push_exp(1, c0); run_sched(); finish_test();
        @(negedge clk); idle(); clear = 1; start = 1; cfg_count = 1;
        @(negedge clk); idle();
        chk("clear_start_busy", {busy_a, busy_b}, 0);
        chk("clear_start_done", {done_a, done_b}, 0);

        // Randomised tables and store streams.
        for (int t = 0; t < 25; t++) begin
            int cnt;
            for (int i = 0; i < D; i++) begin
                tbl_addr[i] = 4 * $urandom_range(0, 24);
                tbl_data[i] = $urandom_range(0, 15);
            end
            cnt = $urandom_range(0, 9);
            build_random(cnt);
            run_test(cnt, $urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mips_store_monitor.md
Name: mips_store_monitor

Overview:
Synthesizable, parametrised self-check monitor for the single-cycle MIPS core. It watches the core's data-memory write port (memwrite, dataaddr, writedata) and compares stores against a programmed ordered sequence of expected (address, data) pairs. It tolerates one configurable scratch address, enforces a cycle timeout, and reports sticky pass/fail status with diagnostics. It replaces single-store hard-coded benches and sits beside the core, in simulation or on FPGA.

Parameters:
WIDTH, 32, data/address width of the monitored store port
DEPTH, 8, maximum number of expected store entries
TIMEOUT, 1000, maximum RUN cycles before a timeout failure (must be ≥1)
IGNORE_EN, 1, enables silent acceptance of stores to IGNORE_ADDR
IGNORE_ADDR, 80, address whose stores are counted but not checked

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  write expected-table entry (honoured in IDLE only)
cfg_idx  in  $clog2(DEPTH)  table entry index
cfg_addr  in  WIDTH  expected store address
cfg_data  in  WIDTH  expected store data
cfg_count  in  $clog2(DEPTH+1)  number of valid entries, latched on start
start  in  1  begin checking (IDLE only)
clear  in  1  return to IDLE, clear counters, keep table
memwrite  in  1  core store strobe
dataaddr  in  WIDTH  core store address
writedata  in  WIDTH  core store data
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail  out  1  high in FAIL
fail_code  out  2  0=NONE, 1=MISMATCH, 2=TIMEOUT
fail_idx  out  $clog2(DEPTH)  pointer value at mismatch
match_cnt  out  $clog2(DEPTH+1)  expected entries matched so far
ignore_cnt  out  8  ignored stores, saturates at 255
cycle_cnt  out  $clog2(TIMEOUT+1)  RUN cycles elapsed

Behaviour:
- All state updates on rising clk. The port is sampled on the same edge the core commits its store.
- Reset: state IDLE; every output 0; table entries 0; latched count 0. Reset mid-RUN aborts immediately and does not report a failure.
- IDLE:
  - cfg_we writes entry cfg_idx on the next edge.
  - start latches cfg_count and sets pointer, match_cnt, ignore_cnt and cycle_cnt to 0.
  - start with cfg_count=0 goes straight to PASS.
  - start with cfg_count>DEPTH saturates the latched count to DEPTH.
  - Simultaneous cfg_we and start: the write commits and the table is used from the first RUN cycle.
  - memwrite is ignored in IDLE.
- RUN, each cycle:
  - cycle_cnt increments.
  - If memwrite is set and dataaddr/writedata equal entry[ptr]: ptr and match_cnt increment. If this was the last entry, go to PASS on the next edge.
  - Else if memwrite, IGNORE_EN, and dataaddr==IGNORE_ADDR: ignore_cnt increments and there is no check.
  - Else if memwrite: go to FAIL with fail_code=1 and fail_idx=ptr. The address is compared before the ignore rule, so an expected entry at IGNORE_ADDR is checkable.
  - If no transition fired and cycle_cnt==TIMEOUT-1: go to FAIL with fail_code=2.
  - If the final match and the timeout coincide, PASS wins.
- PASS/FAIL are sticky. Counters freeze. cfg_we and start are ignored. Only clear or reset leaves these states, and clear goes to IDLE.
- clear in any state returns to IDLE next edge and zeros counters and fail fields. The table and latched count are retained. clear has priority over start and memwrite.
- Status outputs are registered: pass/fail assert exactly 1 cycle after the deciding store.
- Counters never wrap; ignore_cnt saturates.

Decomposition:
- Package mips_mon_pkg:
  - mon_state_t enum: IDLE, RUN, PASS, FAIL.
  - fail_code_t enum: NONE=0, MISMATCH=1, TIMEOUT=2.
  - store_entry_t packed struct: addr, data.
- One sub-module, mips_store_table: DEPTH-entry store_entry_t register file, one synchronous write port, one combinational read port indexed by ptr, reset to 0.
- The FSM and counters live in the top module.

Test Plan:
- Table {(84,7)}, count=1, start; stores (80,3) then (84,7) → ignore_cnt=1, match_cnt=1, pass=1 one cycle after the (84,7) store, fail_code=0.
- Same table; store (88,7) → fail=1, fail_code=1, fail_idx=0, match_cnt=0; later stores leave status unchanged.
- TIMEOUT=20, count=1, no stores → fail with fail_code=2 after exactly 20 RUN cycles, cycle_cnt=19. With IGNORE_EN=0, a store to 80 gives fail_code=1.
- Table {(0,5),(4,10),(84,7)}, stores in order with idle cycles between → match_cnt steps 1,2,3 then pass. Out-of-order (4,10) first → fail_idx=0.
- Reset asserted mid-RUN after 1 match → all outputs 0 next cycle and table zeroed. Reprogram and rerun passes.
- count=0 start → pass next cycle. Then clear → IDLE, counters 0, table intact. Then start with count=1 and store (84,7) → pass. clear and start together → IDLE.
